// File: rtl/rob_nport.sv
// rob_nport: reorder buffer with N_CDB result-bus snoop ports, in-order
// allocation and retirement, combinational operand lookup with CDB bypass,
// and a single-cycle flush for branch mispredict recovery.
module rob_nport #(
    parameter int ROB_WIDTH  = 4,
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int N_CDB      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        alloc_valid,
    input  logic [REG_WIDTH-1:0]        alloc_arch_num,
    output logic                        alloc_ready,
    output logic [ROB_WIDTH-1:0]        alloc_tag,
    input  logic [N_CDB-1:0]            cdb_valid,
    input  logic [N_CDB*ROB_WIDTH-1:0]  cdb_tag,
    input  logic [N_CDB*DATA_WIDTH-1:0] cdb_data,
    output logic                        commit_valid,
    input  logic                        commit_ready,
    output logic [REG_WIDTH-1:0]        commit_arch_num,
    output logic [DATA_WIDTH-1:0]       commit_data,
    input  logic [ROB_WIDTH-1:0]        read_tag,
    output logic                        read_valid,
    output logic [DATA_WIDTH-1:0]       read_data,
    output logic [ROB_WIDTH:0]          count
);

    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] PTR_ONE  = (ROB_WIDTH+1)'(1);
    localparam logic [ROB_WIDTH:0] FULL_CNT = (ROB_WIDTH+1)'(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [ROB_WIDTH:0]      head_q, head_d;
    logic [ROB_WIDTH:0]      tail_q, tail_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [REG_WIDTH-1:0]    arch_q [DEPTH];
    logic [REG_WIDTH-1:0]    arch_d [DEPTH];
    logic [DATA_WIDTH-1:0]   data_q [DEPTH];
    logic [DATA_WIDTH-1:0]   data_d [DEPTH];

    logic [ROB_WIDTH-1:0]    head_idx;
    logic [ROB_WIDTH-1:0]    tail_idx;
    logic [ROB_WIDTH:0]      count_w;
    logic                    alloc_fire;
    logic                    commit_fire;

    logic [ROB_WIDTH-1:0]    cdb_tag_w  [N_CDB];
    logic [DATA_WIDTH-1:0]   cdb_data_w [N_CDB];
    logic [ROB_WIDTH-1:0]    cdb_off    [N_CDB];
    logic [N_CDB-1:0]        cdb_hit;

    assign head_idx = head_q[ROB_WIDTH-1:0];
    assign tail_idx = tail_q[ROB_WIDTH-1:0];
    assign count_w  = tail_q - head_q;
    assign count    = count_w;

    // Allocation depends on registered occupancy only: a full buffer never
    // accepts in the same cycle that it retires.
    assign alloc_ready = (count_w != FULL_CNT);
    assign alloc_tag   = tail_idx;
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign commit_valid    = (count_w != '0) && valid_q[head_idx];
    assign commit_arch_num = arch_q[head_idx];
    assign commit_data     = data_q[head_idx];
    assign commit_fire     = commit_valid && commit_ready && !flush;

    // Unpack CDB ports; a tag hits only if its distance from head lies
    // inside the occupied window, which handles pointer wrap naturally.
    for (genvar g = 0; g < N_CDB; g++) begin : g_cdb
        assign cdb_tag_w[g]  = cdb_tag[g*ROB_WIDTH +: ROB_WIDTH];
        assign cdb_data_w[g] = cdb_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign cdb_off[g]    = cdb_tag_w[g] - head_idx;
        assign cdb_hit[g]    = cdb_valid[g] && ({1'b0, cdb_off[g]} < count_w);
    end

    // Operand lookup with same-cycle CDB bypass; later ports override earlier.
    always_comb begin
        read_valid = valid_q[read_tag];
        read_data  = data_q[read_tag];
        for (int i = 0; i < N_CDB; i++) begin
            if (cdb_valid[i] && (cdb_tag_w[i] == read_tag)) begin
                read_valid = 1'b1;
                read_data  = cdb_data_w[i];
            end
        end
    end

    // Next-state: flush discards everything, otherwise CDB writes, then
    // allocation at the tail, then retirement at the head.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        arch_d  = arch_q;
        data_d  = data_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
        end else begin
            for (int i = 0; i < N_CDB; i++) begin
                if (cdb_hit[i]) begin
                    data_d[cdb_tag_w[i]]  = cdb_data_w[i];
                    valid_d[cdb_tag_w[i]] = 1'b1;
                end
            end
            if (alloc_fire) begin
                arch_d[tail_idx]  = alloc_arch_num;
                valid_d[tail_idx] = 1'b0;
                tail_d            = tail_q + PTR_ONE;
            end
            if (commit_fire) begin
                head_d = head_q + PTR_ONE;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            arch_q  <= '{default: '0};
            data_q  <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            arch_q  <= arch_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_rob_nport.sv
// tb_rob_nport: directed scenarios plus random traffic against a queue-based
// reference model of the reorder buffer.
module tb_rob_nport;

    localparam int RW    = 4;
    localparam int REGW  = 5;
    localparam int DW    = 32;
    localparam int NC    = 2;
    localparam int DEPTH = 1 << RW;

    logic                clk = 1'b0;
    logic                reset;
    logic                flush;
    logic                alloc_valid;
    logic [REGW-1:0]     alloc_arch_num;
    logic                alloc_ready;
    logic [RW-1:0]       alloc_tag;
    logic [NC-1:0]       cdb_valid;
    logic [NC*RW-1:0]    cdb_tag;
    logic [NC*DW-1:0]    cdb_data;
    logic                commit_valid;
    logic                commit_ready;
    logic [REGW-1:0]     commit_arch_num;
    logic [DW-1:0]       commit_data;
    logic [RW-1:0]       read_tag;
    logic                read_valid;
    logic [DW-1:0]       read_data;
    logic [RW:0]         count;

    rob_nport #(.ROB_WIDTH(RW), .REG_WIDTH(REGW), .DATA_WIDTH(DW), .N_CDB(NC)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_arch_num(alloc_arch_num),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_arch_num(commit_arch_num), .commit_data(commit_data),
        .read_tag(read_tag), .read_valid(read_valid), .read_data(read_data),
        .count(count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: program-order queue of live tags plus per-tag contents.
    int              mq[$];
    bit              m_valid [DEPTH];
    logic [REGW-1:0] m_arch  [DEPTH];
    logic [DW-1:0]   m_data  [DEPTH];
    int              m_next;

    function automatic bit m_occ(input int t);
        foreach (mq[k]) if (mq[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_commit_valid();
        return (mq.size() > 0) && m_valid[mq[0]];
    endfunction

    task automatic model_reset(input bit clear_contents);
        mq.delete();
        m_next = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            if (clear_contents) begin
                m_arch[i] = '0;
                m_data[i] = '0;
            end
        end
    endtask

    task automatic idle();
        flush          = 1'b0;
        alloc_valid    = 1'b0;
        alloc_arch_num = '0;
        cdb_valid      = '0;
        cdb_tag        = '0;
        cdb_data       = '0;
        commit_ready   = 1'b0;
        read_tag       = '0;
    endtask

    task automatic set_cdb(input int port, input int tag, input logic [DW-1:0] d);
        cdb_valid[port]          = 1'b1;
        cdb_tag[port*RW +: RW]   = RW'(tag);
        cdb_data[port*DW +: DW]  = d;
    endtask

    task automatic check_outputs();
        bit          exp_rv;
        logic [DW-1:0] exp_rd;
        bit          exp_cv;
        exp_cv = m_commit_valid();
        chk("alloc_ready", alloc_ready, (mq.size() < DEPTH));
        chk("alloc_tag", alloc_tag, m_next);
        chk("count", count, mq.size());
        chk("commit_valid", commit_valid, exp_cv);
        if (exp_cv) begin
            chk("commit_arch_num", commit_arch_num, m_arch[mq[0]]);
            chk("commit_data", commit_data, m_data[mq[0]]);
        end
        exp_rv = m_valid[read_tag];
        exp_rd = m_data[read_tag];
        for (int i = 0; i < NC; i++) begin
            if (cdb_valid[i] && (int'(cdb_tag[i*RW +: RW]) == int'(read_tag))) begin
                exp_rv = 1'b1;
                exp_rd = cdb_data[i*DW +: DW];
            end
        end
        chk("read_valid", read_valid, exp_rv);
        chk("read_data", read_data, exp_rd);
    endtask

    task automatic model_update();
        bit fire;
        bit can_alloc;
        int t;
        if (flush) begin
            model_reset(1'b0);
            return;
        end
        fire      = commit_ready && m_commit_valid();
        can_alloc = alloc_valid && (mq.size() < DEPTH);
        for (int i = 0; i < NC; i++) begin
            t = int'(cdb_tag[i*RW +: RW]);
            if (cdb_valid[i] && m_occ(t)) begin
                m_data[t]  = cdb_data[i*DW +: DW];
                m_valid[t] = 1'b1;
            end
        end
        if (fire) void'(mq.pop_front());
        if (can_alloc) begin
            m_arch[m_next]  = alloc_arch_num;
            m_valid[m_next] = 1'b0;
            mq.push_back(m_next);
            m_next = (m_next + 1) % DEPTH;
        end
    endtask

    // One clock: check comb outputs mid-cycle, advance model, move past edge.
    task automatic step();
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input int arch);
        idle();
        alloc_valid    = 1'b1;
        alloc_arch_num = REGW'(arch);
        step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_alloc_ready"}, alloc_ready, 1);
        chk({tag, "_alloc_tag"}, alloc_tag, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_commit_valid"}, commit_valid, 0);
        chk({tag, "_commit_arch"}, commit_arch_num, 0);
        chk({tag, "_commit_data"}, commit_data, 0);
        chk({tag, "_read_valid"}, read_valid, 0);
        chk({tag, "_read_data"}, read_data, 0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset(1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Fill all 16 entries, no results yet.
        for (int t = 0; t < DEPTH; t++) do_alloc(t);
        idle();
        step();

        // Result for head arrives while full; hold retirement, then release.
        idle();
        set_cdb(1, 0, 32'hDEADBEEF);
        step();
        idle();
        repeat (3) step();
        @(negedge clk);
        chk("hold_data", commit_data, 32'hDEADBEEF);
        chk("hold_arch", commit_arch_num, 0);
        @(posedge clk);
        #1;
        commit_ready = 1'b1;
        step();
        idle();
        step();

        idle();
        flush = 1'b1;
        step();

        // Out-of-order completion, in-order retirement.
        for (int t = 0; t < 3; t++) do_alloc(t + 8);
        idle(); set_cdb(0, 2, 32'h0000_0202); step();
        idle(); set_cdb(1, 1, 32'h0000_0101); step();
        idle(); step();
        idle(); set_cdb(0, 0, 32'h0000_0A0A); step();
        idle(); commit_ready = 1'b1;
        repeat (3) step();
        idle(); step();

        // Two ports hit the same tag: higher port wins, bypassed to read port.
        do_alloc(17);
        idle();
        set_cdb(0, 3, 32'h11);
        set_cdb(1, 3, 32'h22);
        read_tag = 3;
        step();
        idle(); read_tag = 3; step();
        @(negedge clk);
        chk("dup_tag_entry", read_data, 32'h22);
        @(posedge clk);
        #1;
        idle(); commit_ready = 1'b1; step();

        // 40 alloc/complete/retire triples wrap the pointers twice.
        for (int k = 0; k < 40; k++) begin
            int t;
            t = m_next;
            do_alloc(k % 32);
            idle(); set_cdb(k % NC, t, DW'(t)); step();
            idle(); commit_ready = 1'b1; step();
        end
        idle(); step();

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            idle();
            flush          = ($urandom_range(0, 49) == 0);
            alloc_valid    = ($urandom_range(0, 9) < 6);
            alloc_arch_num = REGW'($urandom);
            commit_ready   = ($urandom_range(0, 9) < 6);
            for (int p = 0; p < NC; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int t;
                    if ((mq.size() > 0) && ($urandom_range(0, 3) != 0))
                        t = mq[$urandom_range(0, mq.size() - 1)];
                    else
                        t = $urandom_range(0, DEPTH - 1);
                    set_cdb(p, t, $urandom);
                end
            end
            if (cdb_valid[0] && $urandom_range(0, 1) == 1) read_tag = cdb_tag[RW-1:0];
            else read_tag = RW'($urandom);
            step();
        end

        // Flush wins over simultaneous alloc and commit.
        idle(); flush = 1'b1; step();
        for (int t = 0; t < 5; t++) do_alloc(t + 20);
        idle(); set_cdb(0, mq[0], 32'hCAFE_0001); step();
        idle(); step();
        idle();
        flush          = 1'b1;
        alloc_valid    = 1'b1;
        alloc_arch_num = 5'd9;
        commit_ready   = 1'b1;
        step();
        idle();
        step();

        // Asynchronous reset in the middle of traffic.
        for (int t = 0; t < 3; t++) do_alloc(t + 1);
        idle(); set_cdb(1, 0, 32'h1234_5678); step();
        idle();
        alloc_valid  = 1'b1;
        commit_ready = 1'b0;
        #2;
        reset = 1'b1;
        alloc_valid = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset(1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        step();
        do_alloc(7);
        idle(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
